rx_frame_checker_module: RTL and testbench

RX_FRAME_CHECKER_MODULE -- requirements
Module: rx_frame_checker_module

---
 rtl/rx_checker_pkg.sv | 20 ++
 rtl/keep_len_decode.sv | 19 +
 rtl/rx_frame_checker_module.sv | 213 +++++++++++++++++++++
 tb/tb_rx_frame_checker_module.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_checker_pkg.sv
// Shared types and widths for the RX frame checker: state encoding, counter widths and AXIS lane count.
package rx_checker_pkg;

  localparam int LANES      = 32;
  localparam int KEEP_CNT_W = 6;
  localparam int LEN_W      = 15;
  localparam int CNT_W      = 32;
  localparam int BYTE_CNT_W = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_OVERSIZE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/keep_len_decode.sv
// Turns an AXIS tkeep into its byte count and whether it is a contiguous run starting at lane 0.
module keep_len_decode
  import rx_checker_pkg::*;
(
  input  logic [LANES-1:0]      i_keep,
  output logic [KEEP_CNT_W-1:0] o_count,
  output logic                  o_contig
);

  // Contiguous from lane 0 means keep+1 is a power of two; all-ones wraps to zero and still qualifies.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < LANES; i++) begin
      o_count = o_count + KEEP_CNT_W'(i_keep[i]);
    end
    o_contig = (i_keep != '0) && ((i_keep & (i_keep + LANES'(1))) == '0);
  end

endmodule

// File: rtl/rx_frame_checker_module.sv
// Per-frame length/keep/FCS checking on the 40G MAC RX AXIS stream with saturating statistics.
// Define RX_PATTERN_CHECK_EN to also check the k mod 256 payload pattern and count data errors.
module rx_frame_checker_module
  import rx_checker_pkg::*;
#(
  parameter int P_MIN_LENGTH = 64,
  parameter int P_MAX_LENGTH = 9600
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stat_rx_status,
  input  logic                  i_clear,
  input  logic                  s_axis_rx_tvalid,
  input  logic [8*LANES-1:0]    s_axis_rx_tdata,
  input  logic [LANES-1:0]      s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  output logic [CNT_W-1:0]      o_frame_cnt,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic [CNT_W-1:0]      o_err_fcs_cnt,
  output logic [CNT_W-1:0]      o_err_len_cnt,
  output logic [CNT_W-1:0]      o_err_data_cnt,
  output logic                  o_err_pulse
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(P_MIN_LENGTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(P_MAX_LENGTH);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d, len_base, len_new;
  logic [LEN_W:0]          len_sum;
  logic                    keep_err_q, keep_err_d, keep_err_new, keep_bad;
  logic [KEEP_CNT_W-1:0]   keep_count;
  logic                    keep_contig;
  logic                    in_idle;

  logic                    done_q, done_d;
  logic [LEN_W-1:0]        done_len_q, done_len_d;
  logic                    done_len_err_q, done_len_err_d;
  logic                    done_fcs_q, done_fcs_d;

  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BYTE_CNT_W:0]     byte_sum;
  logic [CNT_W-1:0]        err_fcs_cnt_q, err_fcs_cnt_d;
  logic [CNT_W-1:0]        err_len_cnt_q, err_len_cnt_d;
  logic                    err_pulse_q, err_pulse_d;

  keep_len_decode u_keep_len_decode (
    .i_keep   (s_axis_rx_tkeep),
    .o_count  (keep_count),
    .o_contig (keep_contig)
  );

  assign in_idle = (state_q == ST_IDLE);

`ifdef RX_PATTERN_CHECK_EN
  logic [2:0]       beat_q, beat_d, beat_idx;
  logic             data_err_q, data_err_d, data_err_new, pat_bad;
  logic             done_data_q, done_data_d;
  logic [CNT_W-1:0] err_data_cnt_q, err_data_cnt_d;

  // Lane i of beat b must carry (32b+i) mod 256, which is simply {b[2:0], i}.
  always_comb begin
    beat_idx = in_idle ? 3'd0 : beat_q;
    pat_bad  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (s_axis_rx_tkeep[i] && (s_axis_rx_tdata[8*i +: 8] != {beat_idx, 5'(i)})) pat_bad = 1'b1;
    end
    data_err_new = (!in_idle && data_err_q) || pat_bad;
  end

  assign o_err_data_cnt = err_data_cnt_q;
`else
  logic data_unused;
  assign data_unused    = ^s_axis_rx_tdata;
  assign o_err_data_cnt = '0;
`endif

  always_comb begin
    len_base     = in_idle ? '0 : len_q;
    len_sum      = {1'b0, len_base} + (LEN_W+1)'(keep_count);
    len_new      = (state_q == ST_OVERSIZE) ? len_q : (len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0]);
    keep_bad     = s_axis_rx_tlast ? !keep_contig : (s_axis_rx_tkeep != '1);
    keep_err_new = (!in_idle && keep_err_q) || keep_bad;

    state_d        = state_q;
    len_d          = len_q;
    keep_err_d     = keep_err_q;
    done_d         = 1'b0;
    done_len_d     = done_len_q;
    done_len_err_d = done_len_err_q;
    done_fcs_d     = done_fcs_q;
`ifdef RX_PATTERN_CHECK_EN
    beat_d         = beat_q;
    data_err_d     = data_err_q;
    done_data_d    = done_data_q;
`endif

    // Losing link status drops any partial frame; the completion stage is left alone.
    if (!i_stat_rx_status) begin
      state_d    = ST_IDLE;
      len_d      = '0;
      keep_err_d = 1'b0;
`ifdef RX_PATTERN_CHECK_EN
      data_err_d = 1'b0;
`endif
    end else if (s_axis_rx_tvalid) begin
      if (s_axis_rx_tlast) begin
        state_d        = ST_IDLE;
        len_d          = '0;
        keep_err_d     = 1'b0;
        done_d         = 1'b1;
        done_len_d     = len_new;
        done_len_err_d = (len_new < MIN_LEN) || (len_new > MAX_LEN) || keep_err_new;
        done_fcs_d     = s_axis_rx_tuser;
`ifdef RX_PATTERN_CHECK_EN
        data_err_d     = 1'b0;
        done_data_d    = data_err_new;
`endif
      end else begin
        state_d    = (!in_idle && (len_new > MAX_LEN)) ? ST_OVERSIZE : ST_FRAME;
        len_d      = len_new;
        keep_err_d = keep_err_new;
`ifdef RX_PATTERN_CHECK_EN
        data_err_d = data_err_new;
        beat_d     = beat_idx + 3'd1;
`endif
      end
    end
  end

  // Statistics lag the tlast beat by one cycle so a clear in that cycle can discard the frame.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    err_fcs_cnt_d = err_fcs_cnt_q;
    err_len_cnt_d = err_len_cnt_q;
    err_pulse_d   = 1'b0;
    byte_sum      = {1'b0, byte_cnt_q} + (BYTE_CNT_W+1)'(done_len_q);
`ifdef RX_PATTERN_CHECK_EN
    err_data_cnt_d = err_data_cnt_q;
`endif
    if (i_clear) begin
      frame_cnt_d   = '0;
      byte_cnt_d    = '0;
      err_fcs_cnt_d = '0;
      err_len_cnt_d = '0;
`ifdef RX_PATTERN_CHECK_EN
      err_data_cnt_d = '0;
`endif
    end else if (done_q) begin
      frame_cnt_d = sat_inc_cnt(frame_cnt_q);
      byte_cnt_d  = byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
      if (done_fcs_q)     err_fcs_cnt_d = sat_inc_cnt(err_fcs_cnt_q);
      if (done_len_err_q) err_len_cnt_d = sat_inc_cnt(err_len_cnt_q);
      err_pulse_d = done_fcs_q || done_len_err_q;
`ifdef RX_PATTERN_CHECK_EN
      if (done_data_q) err_data_cnt_d = sat_inc_cnt(err_data_cnt_q);
      err_pulse_d = err_pulse_d || done_data_q;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      keep_err_q     <= 1'b0;
      done_q         <= 1'b0;
      done_len_q     <= '0;
      done_len_err_q <= 1'b0;
      done_fcs_q     <= 1'b0;
      frame_cnt_q    <= '0;
      byte_cnt_q     <= '0;
      err_fcs_cnt_q  <= '0;
      err_len_cnt_q  <= '0;
      err_pulse_q    <= 1'b0;
`ifdef RX_PATTERN_CHECK_EN
      beat_q         <= '0;
      data_err_q     <= 1'b0;
      done_data_q    <= 1'b0;
      err_data_cnt_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      keep_err_q     <= keep_err_d;
      done_q         <= done_d;
      done_len_q     <= done_len_d;
      done_len_err_q <= done_len_err_d;
      done_fcs_q     <= done_fcs_d;
      frame_cnt_q    <= frame_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      err_fcs_cnt_q  <= err_fcs_cnt_d;
      err_len_cnt_q  <= err_len_cnt_d;
      err_pulse_q    <= err_pulse_d;
`ifdef RX_PATTERN_CHECK_EN
      beat_q         <= beat_d;
      data_err_q     <= data_err_d;
      done_data_q    <= done_data_d;
      err_data_cnt_q <= err_data_cnt_d;
`endif
    end
  end

  assign o_frame_cnt   = frame_cnt_q;
  assign o_byte_cnt    = byte_cnt_q;
  assign o_err_fcs_cnt = err_fcs_cnt_q;
  assign o_err_len_cnt = err_len_cnt_q;
  assign o_err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_rx_frame_checker_module.sv
// Randomized bench for rx_frame_checker_module: frames are built as beat queues and scored by a frame-level model.
module tb_rx_frame_checker_module;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 9600;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_stat_rx_status;
  logic         i_clear;
  logic         s_axis_rx_tvalid;
  logic [255:0] s_axis_rx_tdata;
  logic [31:0]  s_axis_rx_tkeep;
  logic         s_axis_rx_tlast;
  logic         s_axis_rx_tuser;
  logic [31:0]  o_frame_cnt;
  logic [47:0]  o_byte_cnt;
  logic [31:0]  o_err_fcs_cnt;
  logic [31:0]  o_err_len_cnt;
  logic [31:0]  o_err_data_cnt;
  logic         o_err_pulse;

  int total = 0;
  int bad   = 0;

  logic [255:0] qData[$];
  logic [31:0]  qKeep[$];
  logic         frameUser;

  logic [63:0] expFrames, expBytes, expFcs, expLen, expData;
  logic        expPulse;

  rx_frame_checker_module dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_stat_rx_status (i_stat_rx_status),
    .i_clear          (i_clear),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tuser  (s_axis_rx_tuser),
    .o_frame_cnt      (o_frame_cnt),
    .o_byte_cnt       (o_byte_cnt),
    .o_err_fcs_cnt    (o_err_fcs_cnt),
    .o_err_len_cnt    (o_err_len_cnt),
    .o_err_data_cnt   (o_err_data_cnt),
    .o_err_pulse      (o_err_pulse)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] satAdd(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] maxV;
    maxV = (64'd1 << w) - 64'd1;
    return ((a + b) > maxV) ? maxV : (a + b);
  endfunction

  task automatic idleInputs();
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tdata  = {8{$urandom()}};
    s_axis_rx_tkeep  = $urandom();
    s_axis_rx_tlast  = 1'($urandom_range(0, 1));
    s_axis_rx_tuser  = 1'($urandom_range(0, 1));
  endtask

  // Payload byte k of the frame carries k mod 256; holeBeat knocks one lane out of a non-last beat.
  task automatic buildFrame(input int nbytes, input int corrupt, input int holeBeat);
    int nbeats;
    logic [255:0] d;
    logic [31:0] k;
    qData.delete();
    qKeep.delete();
    nbeats = (nbytes + 31) / 32;
    for (int b = 0; b < nbeats; b++) begin
      for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'((32 * b + i) % 256);
      if (b == nbeats - 1) k = 32'((64'd1 << (nbytes - 32 * b)) - 64'd1);
      else k = '1;
      if (b == holeBeat && b != nbeats - 1) k[$urandom_range(0, 31)] = 1'b0;
      qData.push_back(d);
      qKeep.push_back(k);
    end
    if (corrupt >= 0 && corrupt < nbytes) begin
      d = qData[corrupt / 32];
      d[8 * (corrupt % 32) +: 8] = ~d[8 * (corrupt % 32) +: 8];
      qData[corrupt / 32] = d;
    end
  endtask

  task automatic applyStimulus(input int stopAfter);
    int nb;
    nb = (stopAfter >= 0) ? stopAfter : qKeep.size();
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) begin
        idleInputs();
        tick();
      end
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tdata  = qData[b];
      s_axis_rx_tkeep  = qKeep[b];
      s_axis_rx_tlast  = (b == qKeep.size() - 1);
      s_axis_rx_tuser  = s_axis_rx_tlast ? frameUser : 1'($urandom_range(0, 1));
      tick();
    end
    idleInputs();
  endtask

  // Frame-level reference: length freezes once it passes the maximum before the last beat.
  task automatic modelFrame();
    int len;
    bit frozen, keepErr, dataErr, lenErr, ok, last;
    logic [31:0] k;
    logic [255:0] d;
    len = 0; frozen = 0; keepErr = 0; dataErr = 0;
    for (int b = 0; b < qKeep.size(); b++) begin
      k = qKeep[b];
      d = qData[b];
      last = (b == qKeep.size() - 1);
      if (!frozen) begin
        len += $countones(k);
        if (len > 32767) len = 32767;
      end
      if (!last && len > MAX_LEN) frozen = 1;
      if (!last && k != 32'hFFFF_FFFF) keepErr = 1;
      if (last) begin
        ok = 0;
        for (int n = 1; n <= 32; n++) if (k == 32'((64'd1 << n) - 64'd1)) ok = 1;
        if (!ok) keepErr = 1;
      end
`ifdef RX_PATTERN_CHECK_EN
      for (int i = 0; i < 32; i++) if (k[i] && d[8*i +: 8] != 8'((32 * b + i) % 256)) dataErr = 1;
`endif
    end
    lenErr    = (len < MIN_LEN) || (len > MAX_LEN) || keepErr;
    expFrames = satAdd(expFrames, 1, 32);
    expBytes  = satAdd(expBytes, 64'(len), 48);
    if (frameUser) expFcs = satAdd(expFcs, 1, 32);
    if (lenErr) expLen = satAdd(expLen, 1, 32);
    if (dataErr) expData = satAdd(expData, 1, 32);
    expPulse = lenErr || frameUser || dataErr;
  endtask

  task automatic zeroModel();
    expFrames = 0; expBytes = 0; expFcs = 0; expLen = 0; expData = 0; expPulse = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".frames"}, 64'(o_frame_cnt), expFrames);
    checkOutput({tag, ".bytes"}, 64'(o_byte_cnt), expBytes);
    checkOutput({tag, ".fcs"}, 64'(o_err_fcs_cnt), expFcs);
    checkOutput({tag, ".len"}, 64'(o_err_len_cnt), expLen);
    checkOutput({tag, ".data"}, 64'(o_err_data_cnt), expData);
    checkOutput({tag, ".pulse"}, 64'(o_err_pulse), 64'(expPulse));
  endtask

  task automatic finishFrame(input string tag);
    tick();
    checkAll(tag);
    tick();
    checkOutput({tag, ".pulseEnd"}, 64'(o_err_pulse), 64'd0);
  endtask

  task automatic runFrame(input string tag, input int nbytes, input int corrupt, input int holeBeat, input logic user);
    frameUser = user;
    buildFrame(nbytes, corrupt, holeBeat);
    applyStimulus(-1);
    modelFrame();
    finishFrame(tag);
  endtask

  initial begin
    i_rst = 1'b1;
    i_clear = 1'b0;
    i_stat_rx_status = 1'b1;
    frameUser = 1'b0;
    idleInputs();
    zeroModel();
    tick();
    tick();
    checkAll("reset");
    i_rst = 1'b0;

    runFrame("good64", 64, -1, -1, 1'b0);
    runFrame("runt60", 60, -1, -1, 1'b0);
    runFrame("over9601", 9601, -1, -1, 1'b0);
    runFrame("max9600", 9600, -1, -1, 1'b0);
    runFrame("fcsData", 64, 40, -1, 1'b1);
    runFrame("keepHole", 96, -1, 1, 1'b0);
    runFrame("single20", 20, -1, -1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(1, 300);
      runFrame($sformatf("rand%0d", r), n,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1,
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (n - 1) / 32)) : -1,
               1'($urandom_range(0, 3) == 0));
    end

    // Clear in the cycle after tlast discards the completing runt frame.
    frameUser = 1'b0;
    buildFrame(60, -1, -1);
    applyStimulus(-1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    zeroModel();
    checkAll("clear");
    tick();
    checkOutput("clear.pulseEnd", 64'(o_err_pulse), 64'd0);
    runFrame("afterClear", 64, -1, -1, 1'b0);

    // Status drop mid-frame, plus a complete beat offered while status is low.
    buildFrame(128, -1, -1);
    applyStimulus(2);
    i_stat_rx_status = 1'b0;
    tick();
    s_axis_rx_tvalid = 1'b1;
    s_axis_rx_tkeep  = '1;
    s_axis_rx_tlast  = 1'b1;
    s_axis_rx_tuser  = 1'b1;
    tick();
    idleInputs();
    i_stat_rx_status = 1'b1;
    tick();
    tick();
    expPulse = 1'b0;
    checkAll("statusDrop");
    runFrame("afterDrop", 64, -1, -1, 1'b0);

    // Reset mid-frame abandons the frame and clears every statistic.
    buildFrame(128, -1, -1);
    applyStimulus(2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    zeroModel();
    checkAll("rstMid");
    runFrame("afterRst", 64, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
